// File: rtl/ahb_apb_bridge.sv
// AHB-to-APB bridge: one APB setup+enable access per accepted AHB transfer, 3 decoded slots.
// Write takes 4 cycles, read 3 (incl. address cycle); Hreadyout low stalls the master meanwhile.
module ahb_apb_bridge #(
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int          REGION_BITS = 26
) (
   input  logic        Hclk,
   input  logic        Hresetn,
   input  logic        Hwrite,
   input  logic        Hreadyin,
   input  logic [1:0]  Htrans,
   input  logic [31:0] Haddr,
   input  logic [31:0] Hwdata,
   input  logic [31:0] Prdata,
   output logic        Hreadyout,
   output logic [1:0]  Hresp,
   output logic [31:0] Hrdata,
   output logic [31:0] Paddr,
   output logic [31:0] Pwdata,
   output logic        Pwrite,
   output logic [2:0]  Pselx,
   output logic        Penable
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_WWAIT, ST_WRITE, ST_WENABLE, ST_READ, ST_RENABLE
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] offset, slot, addr_q;
   logic [2:0]  tempselx, sel_q;
   logic        valid, can_accept;
   logic [31:0] paddr_d, pwdata_d;
   logic [2:0]  pselx_d;
   logic        pwrite_d, penable_d, hready_d;

   assign Hresp  = 2'b00;
   assign Hrdata = Prdata;

   always_comb begin
      offset   = Haddr - BASE_ADDR;
      slot     = offset >> REGION_BITS;
      tempselx = 3'b000;
      if (Haddr >= BASE_ADDR) begin
         case (slot)
            32'd0:   tempselx = 3'b001;
            32'd1:   tempselx = 3'b010;
            32'd2:   tempselx = 3'b100;
            default: tempselx = 3'b000;
         endcase
      end
   end

   assign valid      = Hreadyin && (Htrans == 2'b10 || Htrans == 2'b11) && (tempselx != 3'b000);
   assign can_accept = (state == ST_IDLE) || (state == ST_WENABLE) || (state == ST_RENABLE);

   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         state  <= ST_IDLE;
         addr_q <= '0;
         sel_q  <= '0;
      end else begin
         state <= state_nxt;
         if (can_accept && valid) begin
            addr_q <= Haddr;
            sel_q  <= tempselx;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_WENABLE, ST_RENABLE:
            if (valid) state_nxt = Hwrite ? ST_WWAIT : ST_READ;
            else       state_nxt = ST_IDLE;
         ST_WWAIT: state_nxt = ST_WRITE;
         ST_WRITE: state_nxt = ST_WENABLE;
         ST_READ:  state_nxt = ST_RENABLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Outputs are computed from the upcoming state so the registers show the
   // state's values during that state. The read setup is entered on the accepting
   // edge itself, so it takes address/select straight from the bus.
   always_comb begin
      paddr_d   = Paddr;
      pwdata_d  = Pwdata;
      pwrite_d  = Pwrite;
      pselx_d   = 3'b000;
      penable_d = 1'b0;
      hready_d  = 1'b1;
      case (state_nxt)
         ST_WWAIT: hready_d = 1'b0;
         ST_WRITE: begin
            paddr_d  = addr_q;
            pwdata_d = Hwdata;
            pwrite_d = 1'b1;
            pselx_d  = sel_q;
            hready_d = 1'b0;
         end
         ST_READ: begin
            paddr_d  = Haddr;
            pwrite_d = 1'b0;
            pselx_d  = tempselx;
            hready_d = 1'b0;
         end
         ST_WENABLE, ST_RENABLE: begin
            pselx_d   = Pselx;
            penable_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         Paddr     <= '0;
         Pwdata    <= '0;
         Pwrite    <= 1'b0;
         Pselx     <= 3'b000;
         Penable   <= 1'b0;
         Hreadyout <= 1'b1;
      end else begin
         Paddr     <= paddr_d;
         Pwdata    <= pwdata_d;
         Pwrite    <= pwrite_d;
         Pselx     <= pselx_d;
         Penable   <= penable_d;
         Hreadyout <= hready_d;
      end
   end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Bench for ahb_apb_bridge: cycle-exact AHB master tasks plus an APB access scoreboard.
module tb_ahb_apb_bridge;

   logic        Hclk = 1'b0;
   logic        Hresetn;
   logic        Hwrite;
   logic        Hreadyin;
   logic [1:0]  Htrans;
   logic [31:0] Haddr, Hwdata, Prdata;
   logic        Hreadyout;
   logic [1:0]  Hresp;
   logic [31:0] Hrdata, Paddr, Pwdata;
   logic        Pwrite, Penable;
   logic [2:0]  Pselx;

   typedef struct {
      logic [31:0] addr;
      logic        write;
      logic [31:0] data;
      logic [2:0]  sel;
   } apb_exp_t;

   apb_exp_t exp_q[$];
   int checks = 0;
   int errors = 0;

   always #5 Hclk = ~Hclk;
   assign Hreadyin = Hreadyout;

   ahb_apb_bridge dut (
      .Hclk(Hclk), .Hresetn(Hresetn), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
      .Htrans(Htrans), .Haddr(Haddr), .Hwdata(Hwdata), .Prdata(Prdata),
      .Hreadyout(Hreadyout), .Hresp(Hresp), .Hrdata(Hrdata), .Paddr(Paddr),
      .Pwdata(Pwdata), .Pwrite(Pwrite), .Pselx(Pselx), .Penable(Penable)
   );

   // Each completed APB access (enable phase) is popped against the scoreboard.
   always @(negedge Hclk) begin
      if (Hresetn && Penable && Pselx != 3'b000) begin
         apb_exp_t e;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL apb_unexpected: addr=%h sel=%b with no access expected", Paddr, Pselx);
         end else begin
            e = exp_q.pop_front();
            if (Paddr !== e.addr || Pwrite !== e.write || Pselx !== e.sel ||
                (e.write && Pwdata !== e.data)) begin
               errors++;
               $display("FAIL apb_access: got addr=%h wr=%b data=%h sel=%b, want addr=%h wr=%b data=%h sel=%b",
                        Paddr, Pwrite, Pwdata, Pselx, e.addr, e.write, e.data, e.sel);
            end
         end
      end
   end

   task automatic tick();
      @(posedge Hclk);
      #1;
   endtask

   task automatic check_bus(string name, logic exp_rdy, logic [2:0] exp_sel, logic exp_en);
      @(negedge Hclk);
      checks++;
      if (Hreadyout !== exp_rdy || Pselx !== exp_sel || Penable !== exp_en || Hresp !== 2'b00) begin
         errors++;
         $display("FAIL %s: got rdy=%b sel=%b en=%b resp=%b, want rdy=%b sel=%b en=%b resp=00",
                  name, Hreadyout, Pselx, Penable, Hresp, exp_rdy, exp_sel, exp_en);
      end
   endtask

   task automatic test_reset();
      Hresetn = 1'b0; Hwrite = 1'b0; Htrans = 2'b00;
      Haddr = 32'h8000_0001; Hwdata = '0; Prdata = '0;
      #12;
      checks++;
      if (Paddr !== 32'h0 || Pwdata !== 32'h0 || Pwrite !== 1'b0) begin
         errors++;
         $display("FAIL reset_regs: paddr=%h pwdata=%h pwrite=%b, want all 0", Paddr, Pwdata, Pwrite);
      end
      @(negedge Hclk);
      Hresetn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_bus("idle_after_reset", 1'b1, 3'b000, 1'b0);
      end
   endtask

   task automatic do_write(logic [31:0] addr, logic [31:0] data, logic [2:0] sel);
      tick();
      Htrans = 2'b10; Hwrite = 1'b1; Haddr = addr;
      exp_q.push_back('{addr, 1'b1, data, sel});
      tick();
      Htrans = 2'b00; Hwdata = data;
      check_bus("wr_wwait", 1'b0, 3'b000, 1'b0);
      tick();
      check_bus("wr_setup", 1'b0, sel, 1'b0);
      checks++;
      if (Paddr !== addr || Pwdata !== data || Pwrite !== 1'b1) begin
         errors++;
         $display("FAIL wr_setup_data: got %h/%h/%b want %h/%h/1", Paddr, Pwdata, Pwrite, addr, data);
      end
      tick();
      check_bus("wr_enable", 1'b1, sel, 1'b1);
      tick();
      check_bus("wr_idle", 1'b1, 3'b000, 1'b0);
   endtask

   task automatic do_read(logic [31:0] addr, logic [31:0] rdata, logic [2:0] sel);
      tick();
      Htrans = 2'b10; Hwrite = 1'b0; Haddr = addr; Prdata = rdata;
      exp_q.push_back('{addr, 1'b0, 32'h0, sel});
      tick();
      Htrans = 2'b00;
      check_bus("rd_setup", 1'b0, sel, 1'b0);
      tick();
      check_bus("rd_enable", 1'b1, sel, 1'b1);
      checks++;
      if (Hrdata !== rdata || Pwrite !== 1'b0) begin
         errors++;
         $display("FAIL rd_data: got hrdata=%h pwrite=%b want %h/0", Hrdata, Pwrite, rdata);
      end
      tick();
      check_bus("rd_idle", 1'b1, 3'b000, 1'b0);
   endtask

   task automatic test_ignored(logic [31:0] addr);
      tick();
      Htrans = 2'b10; Hwrite = 1'b0; Haddr = addr;
      tick();
      Htrans = 2'b00;
      check_bus("ignored_1", 1'b1, 3'b000, 1'b0);
      tick();
      check_bus("ignored_2", 1'b1, 3'b000, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [3:0] en_seq;
      logic [3:0] rdy_seq;
      tick();
      Htrans = 2'b10; Hwrite = 1'b1; Haddr = 32'h8000_0004;
      exp_q.push_back('{32'h8000_0004, 1'b1, 32'h55, 3'b001});
      tick();
      Htrans = 2'b00; Hwdata = 32'h55;
      tick();
      @(negedge Hclk); en_seq[3] = Penable; rdy_seq[3] = Hreadyout;
      tick();
      Htrans = 2'b10; Hwrite = 1'b0; Haddr = 32'h8400_0008; Prdata = 32'h1234_5678;
      exp_q.push_back('{32'h8400_0008, 1'b0, 32'h0, 3'b010});
      @(negedge Hclk); en_seq[2] = Penable; rdy_seq[2] = Hreadyout;
      tick();
      Htrans = 2'b00;
      @(negedge Hclk); en_seq[1] = Penable; rdy_seq[1] = Hreadyout;
      checks++;
      if (Pselx !== 3'b010 || Paddr !== 32'h8400_0008) begin
         errors++;
         $display("FAIL b2b_read_setup: got sel=%b addr=%h want 010/84000008", Pselx, Paddr);
      end
      tick();
      @(negedge Hclk); en_seq[0] = Penable; rdy_seq[0] = Hreadyout;
      checks++;
      if (en_seq !== 4'b0101 || rdy_seq !== 4'b0101) begin
         errors++;
         $display("FAIL b2b_sequence: penable=%b hready=%b want 0101/0101", en_seq, rdy_seq);
      end
      checks++;
      if (Hrdata !== 32'h1234_5678) begin
         errors++;
         $display("FAIL b2b_hrdata: got %h want 12345678", Hrdata);
      end
      tick();
      check_bus("b2b_idle", 1'b1, 3'b000, 1'b0);
   endtask

   task automatic test_reset_mid_write();
      tick();
      Htrans = 2'b10; Hwrite = 1'b1; Haddr = 32'h8800_0020;
      tick();
      Htrans = 2'b00; Hwdata = 32'hCAFE_F00D;
      tick();
      tick();
      checks++;
      if (Penable !== 1'b1 || Pselx !== 3'b100) begin
         errors++;
         $display("FAIL rst_mid_pre: got en=%b sel=%b want 1/100", Penable, Pselx);
      end
      Hresetn = 1'b0;
      #2;
      checks++;
      if (Penable !== 1'b0 || Pselx !== 3'b000 || Pwrite !== 1'b0 || Hreadyout !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_abort: got en=%b sel=%b wr=%b rdy=%b want 0/000/0/1",
                  Penable, Pselx, Pwrite, Hreadyout);
      end
      @(negedge Hclk);
      @(negedge Hclk);
      Hresetn = 1'b1;
      do_read(32'h8000_0010, 32'hA5A5_0001, 3'b001);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      test_reset();
      do_write(32'h8000_0001, 32'h0000_00A3, 3'b001);
      do_read(32'h8000_00A2, 32'hDEAD_BEEF, 3'b001);
      do_read(32'h8400_0010, 32'h0BAD_F00D, 3'b010);
      do_write(32'h8800_0000, 32'h1357_9BDF, 3'b100);
      test_ignored(32'h8C00_0000);
      test_ignored(32'h7FFF_FFFC);
      test_back_to_back();
      test_reset_mid_write();
      repeat (2) tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d accesses never seen, want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ahb_apb_bridge.md
Name: ahb_apb_bridge

Overview:
AHB-to-APB bridge slave. It sits directly downstream of the AHB master.
- AHB side: samples Haddr/Hwrite/Htrans/Hwdata; stretches the AHB transfer with Hreadyout.
- APB side: converts each accepted transfer into an APB setup+enable access to one of three APB peripherals.
- Single clock. Non-pipelined on the APB side: one transfer in flight at a time.

Parameters:
BASE_ADDR, 32'h8000_0000, start of the bridged address window.
REGION_BITS, 26, log2 of each peripheral region size (64 MB per slot).

Ports:
Hclk  in  1  system clock, all logic on rising edge
Hresetn  in  1  asynchronous active-low reset
Hwrite  in  1  transfer direction from master (1 = write)
Hreadyin  in  1  bus ready seen by master (Hreadyout fed back in system)
Htrans  in  2  AHB transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
Haddr  in  32  AHB address
Hwdata  in  32  AHB write data (valid in data phase)
Prdata  in  32  APB read data from selected peripheral
Hreadyout  out  1  bridge ready to master
Hresp  out  2  transfer response
Hrdata  out  32  read data to master
Paddr  out  32  APB address
Pwdata  out  32  APB write data
Pwrite  out  1  APB direction
Pselx  out  3  one-hot APB peripheral select
Penable  out  1  APB enable (access phase)

Behaviour:
- Reset (Hresetn low, asynchronous, any state): state=ST_IDLE, Hreadyout=1, Penable=0, Pselx=0, Pwrite=0, Paddr=0, Pwdata=0, internal address/data/select registers=0.
  - Reset mid-transfer aborts it: Pselx/Penable drop immediately, with no completion.
- Decode:
  - slot = (Haddr - BASE_ADDR) >> REGION_BITS.
  - Slots 0, 1, 2 give tempselx 3'b001, 3'b010, 3'b100. Any other slot, or Haddr < BASE_ADDR, gives 0.
- valid = Hreadyin AND Htrans in {10, 11} AND tempselx != 0.
  - IDLE/BUSY transfers and out-of-range addresses are ignored; no error is raised.
- Hresp is constant 2'b00 (OKAY).
- Hrdata = Prdata, combinational pass-through.
- All other outputs are registered.
- Acceptance: on an edge where state is ST_IDLE, ST_WENABLE or ST_RENABLE and valid=1, latch Haddr into addr_q, Hwrite into write_q, and tempselx into sel_q.
- FSM (registered outputs shown are the values during the state):
  - ST_IDLE: Hreadyout=1, Pselx=0, Penable=0.
    - valid & Hwrite -> ST_WWAIT.
    - valid & !Hwrite -> ST_READ.
    - else stay.
  - ST_WWAIT: Hreadyout=0. Capture Hwdata into wdata_q on the exiting edge -> ST_WRITE.
  - ST_WRITE (APB setup): Paddr=addr_q, Pwdata=wdata_q, Pwrite=1, Pselx=sel_q, Penable=0, Hreadyout=0 -> ST_WENABLE.
  - ST_WENABLE (APB access): Penable=1, Paddr/Pwdata/Pwrite/Pselx held, Hreadyout=1.
    - valid -> ST_WWAIT/ST_READ per Hwrite.
    - else -> ST_IDLE.
  - ST_READ (APB setup): Paddr=addr_q, Pwrite=0, Pselx=sel_q, Penable=0, Hreadyout=0 -> ST_RENABLE.
  - ST_RENABLE (APB access): Penable=1, signals held, Hreadyout=1. Master samples Hrdata at the end of this cycle. Next state as ST_WENABLE.
- Latency, counted from the edge that samples the address:
  - Write: Penable high in the 3rd cycle; 4 cycles total including the address cycle.
  - Read: Penable high in the 2nd cycle; 3 cycles total.
- Return to idle: on leaving an enable state to ST_IDLE, Pselx and Penable return to 0 on that edge. Pselx is never nonzero in ST_IDLE or ST_WWAIT.
- Back-to-back: a new transfer accepted in an enable state goes straight to the next setup path. There is no IDLE bubble, but Penable always drops for at least one cycle between accesses.
- Hreadyout low holds the master: Haddr/Hwdata must stay stable. The bridge samples Haddr only in states where Hreadyout=1.

Test Plan:
- Reset then idle: Htrans=00 with Haddr=0x8000_0001 for 5 cycles -> Pselx=0, Penable=0, Hreadyout=1 throughout.
- Single write: NONSEQ, Hwrite=1, Haddr=0x8000_0001, then Hwdata=0xA3 -> WRITE cycle shows Paddr=0x8000_0001, Pwdata=0xA3, Pwrite=1, Pselx=001, Penable=0. Next cycle Penable=1, Hreadyout=1. Then idle.
- Single read: NONSEQ, Hwrite=0, Haddr=0x8000_00A2, Prdata=0xDEADBEEF -> READ cycle shows Pselx=001, Penable=0. RENABLE cycle shows Penable=1, Hrdata=0xDEADBEEF, Hreadyout=1.
- Decode: Haddr=0x8400_0010 -> Pselx=010. Haddr=0x8800_0000 -> Pselx=100. Haddr=0x8C00_0000 or 0x7FFF_FFFC -> ignored, stays ST_IDLE, Hreadyout=1.
- Back-to-back: write 0x8000_0004/0x55 followed immediately by read 0x8400_0008 -> read setup follows WENABLE with no IDLE cycle. Penable sequence 0,1,0,1; Pselx switches 001 -> 010.
- Reset mid-write: assert Hresetn=0 during ST_WENABLE -> Penable, Pselx, Pwrite go 0 immediately (before next edge), Hreadyout=1. After release, a new read completes normally.
